cache_mem_arbiter: RTL and testbench

//  Shares the single main-memory port between the I-cache and the D-cache refill/writeback engines.

---
 rtl/cache_mem_arbiter_pkg.sv | 15 +
 rtl/cache_mem_arbiter_if.sv | 25 ++
 rtl/cache_mem_arbiter_rr_pick2.sv | 24 ++
 rtl/cache_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/memory arbiter: FSM states and grant codes.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbBusy = 2'd1,
        ArbDone = 2'd2
    } arb_state_e;

    typedef enum logic {
        GntI = 1'b0,
        GntD = 1'b1
    } gnt_e;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Simple request/complete memory port. The same shape is used on both cache
// ports and on the memory side, so each cache sees a private memory.
interface cache_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] req_addr;
    logic              req_valid;
    logic              req_wr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] req_rdata;
    logic              req_ready;

    // Requester side: issues the request, receives data and completion.
    modport master (
        output req_addr, req_valid, req_wr, req_wdata,
        input  req_rdata, req_ready
    );

    // Responder side: accepts the request, returns data and completion.
    modport slave (
        input  req_addr, req_valid, req_wr, req_wdata,
        output req_rdata, req_ready
    );
endinterface

// File: rtl/cache_mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins; on a tie the
// requester that was not served last wins.
module cache_mem_arbiter_rr_pick2
    import cache_mem_arbiter_pkg::*;
(
    input  logic valid_i,
    input  logic valid_d,
    input  gnt_e last,
    output gnt_e grant,
    output logic any
);

    // Grant selection
    always_comb begin
        any   = valid_i | valid_d;
        grant = GntI;
        if (valid_i && valid_d) begin
            grant = (last == GntI) ? GntD : GntI;
        end else if (valid_d) begin
            grant = GntD;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache engines.
// One outstanding transaction, round-robin grant, watchdog abort on a stuck memory.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_mem_arbiter_if.slave    i_port,
    cache_mem_arbiter_if.slave    d_port,
    cache_mem_arbiter_if.master   mem_port,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    gnt_e              grant_q, last_q, pick_grant;
    logic              pick_any;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              valid_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic done_ok, done_to, complete;

    cache_mem_arbiter_rr_pick2 u_pick (
        .valid_i (i_port.req_valid),
        .valid_d (d_port.req_valid),
        .last    (last_q),
        .grant   (pick_grant),
        .any     (pick_any)
    );

    // Completion decode; a ready arriving on the timeout cycle counts as normal completion
    always_comb begin
        done_ok  = (state_q == ArbBusy) && mem_port.req_ready;
        done_to  = (state_q == ArbBusy) && !mem_port.req_ready &&
                   (cnt_q == CNT_W'(TIMEOUT));
        complete = done_ok || done_to;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ArbIdle: if (pick_any) state_d = ArbBusy;
            ArbBusy: if (complete) state_d = ArbDone;
            ArbDone: state_d = ArbIdle;
            default: state_d = ArbIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ArbIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, watchdog counter, round-robin history and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= GntI;
            last_q  <= GntD;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ArbIdle: begin
                    if (pick_any) begin
                        grant_q <= pick_grant;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        if (pick_grant == GntD) begin
                            addr_q  <= d_port.req_addr;
                            wr_q    <= d_port.req_wr;
                            wdata_q <= d_port.req_wdata;
                        end else begin
                            addr_q  <= i_port.req_addr;
                            wr_q    <= i_port.req_wr;
                            wdata_q <= i_port.req_wdata;
                        end
                    end
                end
                ArbBusy: begin
                    if (done_ok) begin
                        valid_q <= 1'b0;
                        last_q  <= grant_q;
                    end else if (done_to) begin
                        // An aborted transaction does not move the round-robin history
                        valid_q <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        // Cannot wrap: reaching TIMEOUT always leaves BUSY
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ArbDone: begin
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                end
                default: begin
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Memory-side drive and completion routing to the granted cache only
    always_comb begin
        mem_port.req_addr  = addr_q;
        mem_port.req_valid = valid_q;
        mem_port.req_wr    = wr_q;
        mem_port.req_wdata = wdata_q;

        i_port.req_ready = complete && (grant_q == GntI);
        d_port.req_ready = complete && (grant_q == GntD);
        i_port.req_rdata = (done_ok && (grant_q == GntI)) ? mem_port.req_rdata : '0;
        d_port.req_rdata = (done_ok && (grant_q == GntD)) ? mem_port.req_rdata : '0;

        busy        = (state_q != ArbIdle);
        err_timeout = err_q;
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a completion scoreboard.
module tb_cache_mem_arbiter;

    localparam int unsigned TO = 4;

    logic clk;
    logic rst;
    logic busy;
    logic err_timeout;

    int checks   = 0;
    int failures = 0;

    // {d_ready, i_ready, rdata} expected per completion pulse
    logic [33:0] sb[$];

    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) i_if ();
    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) d_if ();
    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

    cache_mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_port      (i_if),
        .d_port      (d_if),
        .mem_port    (m_if),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("%s differs", tag);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Every completion pulse must match the oldest pending expectation
    always @(negedge clk) begin
        logic [33:0] obs;
        logic [33:0] exp;
        if (i_if.req_ready || d_if.req_ready) begin
            obs = {d_if.req_ready, i_if.req_ready,
                   d_if.req_ready ? d_if.req_rdata : i_if.req_rdata};
            exp = (sb.size() != 0) ? sb.pop_front() : 34'h0;
            check("sb_pulse", 64'(obs), 64'(exp));
        end
    end

    // Entered at posedge+1 of the first BUSY cycle; memory answers on BUSY cycle 'lat'.
    // Returns at posedge+1 of the IDLE cycle that follows DONE.
    task automatic busy_phase(input int lat, input logic [31:0] rdata, input logic [1:0] port,
                              input logic [31:0] addr, input logic wr,
                              input logic [31:0] wdata, input logic keep);
        for (int b = 1; b <= lat; b++) begin
            if (b == lat) begin
                m_if.req_ready = 1'b1;
                m_if.req_rdata = rdata;
                sb.push_back({port, rdata});
            end
            @(negedge clk);
            check("bp_valid", 64'(m_if.req_valid), 64'd1);
            check("bp_addr", 64'(m_if.req_addr), 64'(addr));
            check("bp_wr", 64'(m_if.req_wr), 64'(wr));
            check("bp_wdata", 64'(m_if.req_wdata), 64'(wdata));
            check("bp_ready", 64'({d_if.req_ready, i_if.req_ready}),
                  64'((b == lat) ? port : 2'b00));
            check("bp_other_rdata", 64'(port == 2'b01 ? d_if.req_rdata : i_if.req_rdata), 64'd0);
            cyc();
        end
        m_if.req_ready = 1'b0;
        m_if.req_rdata = '0;
        if (!keep) begin
            i_if.req_valid = 1'b0;
            d_if.req_valid = 1'b0;
        end
        @(negedge clk);
        check("done_busy", 64'(busy), 64'd1);
        check("done_valid", 64'(m_if.req_valid), 64'd0);
        check("done_ready", 64'({d_if.req_ready, i_if.req_ready}), 64'd0);
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        i_if.req_addr = '0; i_if.req_valid = 1'b0; i_if.req_wr = 1'b0; i_if.req_wdata = '0;
        d_if.req_addr = '0; d_if.req_valid = 1'b0; d_if.req_wr = 1'b0; d_if.req_wdata = '0;
        m_if.req_rdata = '0; m_if.req_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(m_if.req_valid), 64'd0);
        check("rst_wr", 64'(m_if.req_wr), 64'd0);
        check("rst_addr", 64'(m_if.req_addr), 64'd0);
        check("rst_wdata", 64'(m_if.req_wdata), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        cyc();

        // 1: I-only read, one-cycle grant latency, data on third BUSY cycle
        i_if.req_valid = 1'b1; i_if.req_addr = 32'h40; i_if.req_wr = 1'b0;
        @(negedge clk);
        check("t1_latency", 64'(m_if.req_valid), 64'd0);
        cyc();
        busy_phase(3, 32'hDEADBEEF, 2'b01, 32'h40, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("t1_idle", 64'(busy), 64'd0);
        cyc();

        // 2: D write, request inputs change mid-BUSY but the latched copy is driven
        d_if.req_valid = 1'b1; d_if.req_addr = 32'h80; d_if.req_wr = 1'b1;
        d_if.req_wdata = 32'h12345678;
        @(negedge clk);
        check("t2_latency", 64'(m_if.req_valid), 64'd0);
        cyc();
        d_if.req_wdata = 32'h0; d_if.req_wr = 1'b0;
        busy_phase(3, 32'hA5A50002, 2'b10, 32'h80, 1'b1, 32'h12345678, 1'b0);

        // 3: both valid from reset, alternating grants with one DONE gap
        rst = 1'b1;
        i_if.req_valid = 1'b1; i_if.req_addr = 32'h100;
        d_if.req_valid = 1'b1; d_if.req_addr = 32'h200;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_gap", 64'(busy), 64'd0);
            cyc();
            busy_phase(2, 32'hC0DE0000 + 32'(k), (k % 2 == 0) ? 2'b01 : 2'b10,
                       (k % 2 == 0) ? 32'h100 : 32'h200, 1'b0, 32'h0, 1'b1);
        end
        i_if.req_valid = 1'b0;
        d_if.req_valid = 1'b0;
        @(negedge clk);
        cyc();

        // 4: address change and valid drop mid-BUSY do not disturb the transaction
        i_if.req_valid = 1'b1; i_if.req_addr = 32'h40;
        cyc();
        i_if.req_addr = 32'h44; i_if.req_valid = 1'b0;
        busy_phase(3, 32'h44440040, 2'b01, 32'h40, 1'b0, 32'h0, 1'b0);

        // 5: memory never ready -> abort on the BUSY cycle where cnt reaches TIMEOUT
        d_if.req_valid = 1'b1; d_if.req_addr = 32'h300;
        m_if.req_rdata = 32'hFFFFFFFF;
        cyc();
        for (int b = 1; b <= TO + 1; b++) begin
            if (b == TO + 1) sb.push_back({2'b10, 32'h0});
            @(negedge clk);
            check("t5_ready", 64'({d_if.req_ready, i_if.req_ready}),
                  64'((b == TO + 1) ? 2'b10 : 2'b00));
            check("t5_rdata", 64'(d_if.req_rdata), 64'd0);
            check("t5_err_pre", 64'(err_timeout), 64'd0);
            cyc();
        end
        d_if.req_valid = 1'b0;
        m_if.req_rdata = '0;
        @(negedge clk);
        check("t5_err_set", 64'(err_timeout), 64'd1);
        check("t5_done_valid", 64'(m_if.req_valid), 64'd0);
        cyc();
        i_if.req_valid = 1'b1; i_if.req_addr = 32'h500;
        @(negedge clk);
        check("t5_err_sticky", 64'(err_timeout), 64'd1);
        cyc();
        busy_phase(2, 32'h5555AAAA, 2'b01, 32'h500, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("t5_err_after", 64'(err_timeout), 64'd1);
        cyc();

        // 6: reset in the middle of BUSY drops the transaction silently
        d_if.req_valid = 1'b1; d_if.req_addr = 32'h600;
        cyc();
        @(negedge clk);
        check("t6_busy", 64'(busy), 64'd1);
        cyc();
        rst = 1'b1;
        d_if.req_valid = 1'b0;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("t6_busy_rst", 64'(busy), 64'd0);
        check("t6_valid_rst", 64'(m_if.req_valid), 64'd0);
        check("t6_err_rst", 64'(err_timeout), 64'd0);
        check("t6_addr_rst", 64'(m_if.req_addr), 64'd0);
        cyc();
        m_if.req_ready = 1'b1; m_if.req_rdata = 32'h66666666;
        @(negedge clk);
        check("t6_late_ready", 64'({d_if.req_ready, i_if.req_ready}), 64'd0);
        check("t6_late_rdata", 64'({d_if.req_rdata, i_if.req_rdata}), 64'd0);
        cyc();
        m_if.req_ready = 1'b0; m_if.req_rdata = '0;
        @(negedge clk);
        check("t6_idle", 64'(busy), 64'd0);
        cyc();

        // 7: ready on the timeout cycle is a normal completion, no error
        i_if.req_valid = 1'b1; i_if.req_addr = 32'h700;
        cyc();
        busy_phase(TO + 1, 32'h77777777, 2'b01, 32'h700, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("t7_no_err", 64'(err_timeout), 64'd0);
        check("t7_idle", 64'(busy), 64'd0);

        cyc();
        @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
